// File: rtl/player_hand_if.sv
// Deck/controller-facing bundle for one player's hand.
// The slave modport is the hand itself; master is the controller/deck side.
interface player_hand_if #(
  parameter int IDX_W = 5
);
  logic [2:0]     i_draw_req;
  logic [2:0]     o_draw;
  logic           i_drawn;
  logic [5:0]     i_card;
  logic           i_deck_done;
  logic           i_play;
  logic [IDX_W-1:0] i_sel;
  logic [5:0]     i_top_card;
  logic           o_insert;
  logic [5:0]     o_prev_card;
  logic [IDX_W-1:0] i_view_idx;
  logic [5:0]     o_view_card;
  logic [IDX_W:0] o_count;
  logic           o_busy;
  logic           o_play_err;
  logic           o_uno;
  logic           o_empty;

  modport slave (
    input  i_draw_req, i_drawn, i_card, i_deck_done, i_play, i_sel,
           i_top_card, i_view_idx,
    output o_draw, o_insert, o_prev_card, o_view_card, o_count, o_busy,
           o_play_err, o_uno, o_empty
  );

  modport master (
    output i_draw_req, i_drawn, i_card, i_deck_done, i_play, i_sel,
           i_top_card, i_view_idx,
    input  o_draw, o_insert, o_prev_card, o_view_card, o_count, o_busy,
           o_play_err, o_uno, o_empty
  );
endinterface

// File: rtl/player_hand.sv
// One player's UNO hand: collects drawn cards from the deck, validates and
// removes played cards, and returns them through the deck's insert port.
// Slots stay packed in arrival order; cards are 6 bits {color, value}.
module player_hand #(
  parameter int MAX_CARDS = 32,
  parameter int IDX_W     = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  player_hand_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, REMOVE, INSERT} state_t;

  state_t           state_reg, state_next;
  logic [5:0]       hand_reg   [MAX_CARDS];
  logic [5:0]       hand_next  [MAX_CARDS];
  logic [5:0]       shift_slot [MAX_CARDS];
  logic [IDX_W:0]   count_reg, count_next;
  logic [2:0]       need_reg, need_next;
  logic [2:0]       rcv_reg, rcv_next;
  logic [2:0]       draw_reg, draw_next;
  logic             insert_reg, insert_next;
  logic [5:0]       prev_reg, prev_next;
  logic             err_reg, err_next;
  logic [IDX_W-1:0] sel_reg, sel_next;

  logic [2:0]       req_n;
  logic [IDX_W+1:0] count_after_draw;
  logic             draw_fits;
  logic [5:0]       sel_card;
  logic             sel_in_range;
  logic             play_legal;
  logic             view_in_range;

  // Decode the request code into a card count; unknown codes decode to zero.
  always_comb begin
    req_n = 3'd0;
    case (bus.i_draw_req)
      3'b001:  req_n = 3'd1;
      3'b010:  req_n = 3'd2;
      3'b100:  req_n = 3'd4;
      default: req_n = 3'd0;
    endcase
  end

  assign count_after_draw = {1'b0, count_reg} + (IDX_W+2)'(req_n);
  assign draw_fits        = count_after_draw <= (IDX_W+2)'(MAX_CARDS);

  // Play legality: matching color, matching value, or any wild (value >= 13).
  assign sel_card     = hand_reg[bus.i_sel];
  assign sel_in_range = {1'b0, bus.i_sel} < count_reg;
  assign play_legal   = (sel_card[5:4] == bus.i_top_card[5:4]) ||
                        (sel_card[3:0] == bus.i_top_card[3:0]) ||
                        (sel_card[3:0] >= 4'd13);

  // Close the gap left by the played slot: every slot from the latched
  // selection upward takes its upper neighbour, the old last slot is cleared.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_CARDS; gi++) begin : g_shift
      logic [5:0] upper;
      if (gi < MAX_CARDS - 1) begin : g_mid
        assign upper = hand_reg[gi+1];
      end else begin : g_top
        assign upper = 6'h00;
      end
      // Per-slot value after removal.
      always_comb begin
        shift_slot[gi] = hand_reg[gi];
        if ((IDX_W+1)'(gi + 1) == count_reg)
          shift_slot[gi] = 6'h00;
        else if (((IDX_W+1)'(gi) >= {1'b0, sel_reg}) &&
                 ((IDX_W+1)'(gi + 1) < count_reg))
          shift_slot[gi] = upper;
      end
    end
  endgenerate

  // Next-state and datapath update for the hand FSM.
  always_comb begin
    state_next  = state_reg;
    hand_next   = hand_reg;
    count_next  = count_reg;
    need_next   = need_reg;
    rcv_next    = rcv_reg;
    draw_next   = draw_reg;
    insert_next = insert_reg;
    prev_next   = prev_reg;
    err_next    = 1'b0;
    sel_next    = sel_reg;
    case (state_reg)
      IDLE: begin
        if (req_n != 3'd0) begin
          // A draw takes priority; a simultaneous play is dropped silently.
          if (!draw_fits) begin
            err_next = 1'b1;
          end else begin
            need_next  = req_n;
            rcv_next   = 3'd0;
            draw_next  = bus.i_draw_req;
            state_next = COLLECT;
          end
        end else if (bus.i_play) begin
          if (!sel_in_range || !play_legal) begin
            err_next = 1'b1;
          end else begin
            prev_next  = sel_card;
            sel_next   = bus.i_sel;
            state_next = REMOVE;
          end
        end
      end
      COLLECT: begin
        if (bus.i_drawn) begin
          hand_next[count_reg[IDX_W-1:0]] = bus.i_card;
          count_next = count_reg + 1'b1;
          rcv_next   = rcv_reg + 3'd1;
          if (rcv_reg + 3'd1 == need_reg) begin
            draw_next  = 3'b000;
            state_next = IDLE;
          end
        end
      end
      REMOVE: begin
        hand_next   = shift_slot;
        count_next  = count_reg - 1'b1;
        insert_next = 1'b1;
        state_next  = INSERT;
      end
      INSERT: begin
        if (bus.i_deck_done) begin
          insert_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Hand slots, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < MAX_CARDS; k++) hand_reg[k] <= 6'h00;
      count_reg  <= '0;
      need_reg   <= 3'd0;
      rcv_reg    <= 3'd0;
      draw_reg   <= 3'b000;
      insert_reg <= 1'b0;
      prev_reg   <= 6'h00;
      err_reg    <= 1'b0;
      sel_reg    <= '0;
    end else begin
      hand_reg   <= hand_next;
      count_reg  <= count_next;
      need_reg   <= need_next;
      rcv_reg    <= rcv_next;
      draw_reg   <= draw_next;
      insert_reg <= insert_next;
      prev_reg   <= prev_next;
      err_reg    <= err_next;
      sel_reg    <= sel_next;
    end
  end

  assign view_in_range   = {1'b0, bus.i_view_idx} < count_reg;
  assign bus.o_view_card = view_in_range ? hand_reg[bus.i_view_idx] : 6'h00;
  assign bus.o_draw      = draw_reg;
  assign bus.o_insert    = insert_reg;
  assign bus.o_prev_card = prev_reg;
  assign bus.o_count     = count_reg;
  assign bus.o_busy      = (state_reg != IDLE);
  assign bus.o_play_err  = err_reg;
  assign bus.o_uno       = (count_reg == (IDX_W+1)'(1));
  assign bus.o_empty     = (count_reg == '0);

endmodule
